// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: binary write pointer, full/level/overflow status.
// Optional almost-full output is enabled by defining ASYNC_FIFO_ALMOST_FULL_EN.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AF_THRESHOLD = 12
) (
    input  logic                  src_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    input  logic                  ovf_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_bin,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int            PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_WIDTH);

    generate
        if (AF_THRESHOLD < 1 || AF_THRESHOLD > 2**ADDR_WIDTH) begin : g_bad_af
            $error("AF_THRESHOLD must lie in 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic [PW-1:0] ptr_next;
    logic [PW-1:0] diff;
    logic          full_next;
    logic [PW-1:0] level_next;

    assign wr_accept = wr_en & ~full & ~rst;
    assign wr_addr   = wr_ptr_bin[ADDR_WIDTH-1:0];

    // Occupancy is measured against the pointer after this cycle's push so
    // full rises on the same edge that writes the last free slot.
    always_comb begin
        ptr_next   = wr_ptr_bin + PW'(wr_accept);
        diff       = ptr_next - rd_ptr_sync;
        full_next  = (diff >= DEPTH);
        level_next = (diff > DEPTH) ? DEPTH : diff;
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            wr_ptr_bin <= '0;
            full       <= 1'b0;
            level      <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr_bin <= ptr_next;
            full       <= full_next;
            level      <= level_next;
            // a new overflow event takes priority over a simultaneous clear
            if (wr_en && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    always_ff @(posedge src_clk) begin
        if (rst)
            almost_full <= 1'b0;
        else
            almost_full <= (level_next >= PW'(AF_THRESHOLD));
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed vector table, hand sequences, random traffic vs. an occupancy model.
module tb_async_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AFT   = 12;

    logic       src_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] rd_ptr_sync = '0;
    logic       ovf_clr = 1'b0;
    logic       wr_accept;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_bin;
    logic       full;
    logic [4:0] level;
    logic       overflow;
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    async_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESHOLD(AFT)) dut (
        .src_clk     (src_clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_ptr_sync (rd_ptr_sync),
        .ovf_clr     (ovf_clr),
        .wr_accept   (wr_accept),
        .wr_addr     (wr_addr),
        .wr_ptr_bin  (wr_ptr_bin),
        .full        (full),
        .level       (level),
        .overflow    (overflow)
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 src_clk = ~src_clk;

    int checks = 0;
    int errors = 0;

    // Model state: total accepted pushes, so the pointer is just a count modulo 2*DEPTH.
    int m_pushes = 0;
    int m_full   = 0;
    int m_level  = 0;
    int m_ovf    = 0;

    function automatic int m_wptr();
        return m_pushes % PMOD;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and check the combinational outputs mid-cycle.
    task automatic drive(input logic r, input logic w, input logic [4:0] rd, input logic c);
        rst = r; wr_en = w; rd_ptr_sync = rd; ovf_clr = c;
        @(negedge src_clk);
        check("wr_accept", int'(wr_accept), int'(w && !r && m_full == 0));
        if (!r) check("wr_addr", int'(wr_addr), m_wptr() % DEPTH);
    endtask

    // Clock edge, advance the model from the spec's rules, check registered outputs.
    task automatic clock_and_check();
        int acc, d;
        @(posedge src_clk);
        if (rst) begin
            m_pushes = 0; m_full = 0; m_level = 0; m_ovf = 0;
        end else begin
            acc = (wr_en && m_full == 0) ? 1 : 0;
            if (wr_en && m_full != 0) m_ovf = 1;
            else if (ovf_clr)         m_ovf = 0;
            m_pushes += acc;
            d = (m_wptr() - int'(rd_ptr_sync) + PMOD) % PMOD;
            m_full  = (d >= DEPTH) ? 1 : 0;
            m_level = (d > DEPTH) ? DEPTH : d;
        end
        #1;
        check("wr_ptr_bin", int'(wr_ptr_bin), m_wptr());
        check("full", int'(full), m_full);
        check("level", int'(level), m_level);
        check("overflow", int'(overflow), m_ovf);
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
        check("almost_full", int'(almost_full), (m_level >= AFT) ? 1 : 0);
`endif
    endtask

    task automatic apply(input logic r, input logic w, input logic [4:0] rd, input logic c);
        drive(r, w, rd, c);
        clock_and_check();
    endtask

    typedef struct {
        logic       r, w;
        logic [4:0] rd;
        logic       c;
        logic       acc;
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       full;
        logic [4:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int occ, step;
        logic [4:0] m_rd;

        // Reset held two cycles with wr_en high
        tbl.push_back('{1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0});
        // Fill 16 entries with the reader parked at 0
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back('{1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 4'(i), 5'(i + 1),
                            (i == DEPTH - 1), 5'(i + 1), 1'b0});
        // Overflow: push while full, clear with a colliding push, then clear alone
        tbl.push_back('{1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 5'd16, 1'b1, 5'd16, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 5'd16, 1'b1, 5'd16, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 5'd16, 1'b1, 5'd16, 1'b0});
        // Drain one, then refill
        tbl.push_back('{1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 5'd16, 1'b0, 5'd15, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 4'd0, 5'd17, 1'b1, 5'd16, 1'b0});

        @(posedge src_clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].c);
            check("tbl_acc", int'(wr_accept), int'(tbl[i].acc));
            if (!tbl[i].r) check("tbl_addr", int'(wr_addr), int'(tbl[i].addr));
            clock_and_check();
            check("tbl_ptr", int'(wr_ptr_bin), int'(tbl[i].ptr));
            check("tbl_full", int'(full), int'(tbl[i].full));
            check("tbl_level", int'(level), int'(tbl[i].lvl));
            check("tbl_ovf", int'(overflow), int'(tbl[i].ovf));
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
            if (i == 2 + AFT - 1) check("tbl_af_at_12", int'(almost_full), 1);
            if (i == 2 + AFT - 2) check("tbl_af_at_11", int'(almost_full), 0);
`endif
        end

        // Wrap: walk the pointer to 31 with the reader tracking it, then push across the wrap
        step = 0;
        while (m_wptr() != 31 && step < 40) begin
            apply(1'b0, 1'b1, 5'(m_wptr()), 1'b0);
            step++;
        end
        check("wrap_reach_31", int'(wr_ptr_bin), 31);
        apply(1'b0, 1'b1, 5'd31, 1'b0);
        check("wrap_ptr", int'(wr_ptr_bin), 0);
        check("wrap_level", int'(level), 1);
        check("wrap_full", int'(full), 0);

        // Saturation: a read pointer implying diff > DEPTH reads as full, level DEPTH
        apply(1'b0, 1'b0, 5'd10, 1'b0);
        check("sat_level", int'(level), DEPTH);
        check("sat_full", int'(full), 1);

        // Reset mid-fill
        apply(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 5'd0, 1'b0);
        check("mid_ptr7", int'(wr_ptr_bin), 7);
        apply(1'b1, 1'b1, 5'd0, 1'b0);
        check("mid_rst_ptr", int'(wr_ptr_bin), 0);
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_full", int'(full), 0);
        drive(1'b0, 1'b1, 5'd0, 1'b0);
        check("mid_resume_addr", int'(wr_addr), 0);
        clock_and_check();
        check("mid_resume_ptr", int'(wr_ptr_bin), 1);

        // Random traffic: reader lags the writer by a legal, slowly advancing pointer
        m_rd = 5'd0;
        for (int n = 0; n < 600; n++) begin
            logic r, w, c;
            logic [4:0] rd;
            r = ($urandom_range(0, 59) == 0);
            w = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0);
            occ = (m_wptr() - int'(m_rd) + PMOD) % PMOD;
            if (occ > 0 && $urandom_range(0, 2) == 0)
                m_rd = 5'(int'(m_rd) + $urandom_range(1, (occ > 3) ? 3 : occ));
            rd = m_rd;
            if ($urandom_range(0, 49) == 0) rd = 5'($urandom_range(0, 31));
            apply(r, w, rd, c);
            if (r) m_rd = 5'd0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
